// File: rtl/frame_config_ctrl.sv
// frame_config_ctrl: takes a header word and then N frame words from a valid/ready stream.
// Each frame word is presented on FrameData and latched into one column with a
// one-hot FrameStrobe/ColSelect pulse.
// Optional build macro FRAME_CHECKSUM_EN adds a trailer word. That trailer is compared
// against the XOR of all frame words.
module frame_config_ctrl #(
  parameter int unsigned NUM_COLS       = 8,
  parameter int unsigned FRAMES_PER_COL = 20,
  parameter int unsigned STROBE_CYCLES  = 2
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [31:0]               s_data,
  output logic [31:0]               FrameData,
  output logic [NUM_COLS-1:0]       ColSelect,
  output logic [FRAMES_PER_COL-1:0] FrameStrobe,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam int unsigned ColW       = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int unsigned IdxW       = (FRAMES_PER_COL > 1) ? $clog2(FRAMES_PER_COL) : 1;
  localparam logic [31:0] NumColsW   = NUM_COLS;
  localparam logic [31:0] MaxFramesW = FRAMES_PER_COL;
  localparam logic [3:0]  StrobeLast = 4'(STROBE_CYCLES - 1);
  localparam logic [15:0] SyncWord   = 16'hFAB0;
  localparam logic [NUM_COLS-1:0]       ColOne = NUM_COLS'(1);
  localparam logic [FRAMES_PER_COL-1:0] FrmOne = FRAMES_PER_COL'(1);

  typedef enum logic [2:0] {StIdle, StLoad, StStrobe, StHold, StCheck, StDone} state_e;

  state_e                    state_q, state_d;
  logic [ColW-1:0]           col_q, col_d;
  logic [IdxW-1:0]           idx_q, idx_d;
  logic [IdxW-1:0]           last_q, last_d;
  logic [3:0]                cnt_q, cnt_d;
  logic [31:0]               frame_data_q, frame_data_d;
  logic [NUM_COLS-1:0]       col_sel_q, col_sel_d;
  logic [FRAMES_PER_COL-1:0] strobe_q, strobe_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;
  logic                      accept;
  logic                      hdr_ok;
`ifdef FRAME_CHECKSUM_EN
  logic [31:0]               csum_q, csum_d;
`endif

  // Stream handshake: ready only in states that consume a word, and never while in reset.
  always_comb begin
    s_ready = 1'b0;
    if (!RST) begin
      case (state_q)
        StIdle:  s_ready = 1'b1;
        StLoad:  s_ready = 1'b1;
`ifdef FRAME_CHECKSUM_EN
        StCheck: s_ready = 1'b1;
`endif
        default: s_ready = 1'b0;
      endcase
    end
  end

  assign accept = s_valid & s_ready;
  assign hdr_ok = (s_data[31:16] == SyncWord) &&
                  ({24'd0, s_data[15:8]} < NumColsW) &&
                  (s_data[7:0] != 8'd0) &&
                  ({24'd0, s_data[7:0]} <= MaxFramesW);

  // Next-state logic. Registered outputs are derived from the next state, so strobes
  // and flags line up exactly with the state that owns them.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    idx_d        = idx_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    frame_data_d = frame_data_q;
    err_d        = 1'b0;
`ifdef FRAME_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (hdr_ok) begin
            col_d   = ColW'(s_data[15:8]);
            last_d  = IdxW'(s_data[7:0] - 8'd1);
            idx_d   = '0;
            state_d = StLoad;
`ifdef FRAME_CHECKSUM_EN
            csum_d  = '0;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StLoad: begin
        if (accept) begin
          frame_data_d = s_data;
          cnt_d        = '0;
          state_d      = StStrobe;
`ifdef FRAME_CHECKSUM_EN
          csum_d       = csum_q ^ s_data;
`endif
        end
      end
      StStrobe: begin
        if (cnt_q == StrobeLast) state_d = StHold;
        else                     cnt_d   = cnt_q + 4'd1;
      end
      StHold: begin
        if (idx_q == last_q) begin
`ifdef FRAME_CHECKSUM_EN
          state_d = StCheck;
`else
          state_d = StDone;
`endif
        end else begin
          idx_d   = idx_q + IdxW'(1);
          state_d = StLoad;
        end
      end
      StCheck: begin
`ifdef FRAME_CHECKSUM_EN
        if (accept) begin
          if (s_data == csum_q) begin
            state_d = StDone;
          end else begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
`else
        state_d = StIdle;
`endif
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    busy_d    = (state_d != StIdle);
    done_d    = (state_d == StDone);
    col_sel_d = (state_d == StStrobe) ? (ColOne << col_d) : '0;
    strobe_d  = (state_d == StStrobe) ? (FrmOne << idx_d) : '0;
  end

  // State and output registers; reset clears strobes asynchronously, abandoning a partial load.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= StIdle;
      col_q        <= '0;
      idx_q        <= '0;
      last_q       <= '0;
      cnt_q        <= '0;
      frame_data_q <= '0;
      col_sel_q    <= '0;
      strobe_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      idx_q        <= idx_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      frame_data_q <= frame_data_d;
      col_sel_q    <= col_sel_d;
      strobe_q     <= strobe_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
`ifdef FRAME_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign FrameData   = frame_data_q;
  assign ColSelect   = col_sel_q;
  assign FrameStrobe = strobe_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_frame_config_ctrl.sv
// Bench for frame_config_ctrl.
// Each column-load transaction is expanded into the per-cycle output waveform that the
// protocol dictates. A negedge compare process checks every cycle against that waveform.
// Literal checks pin the totals observed for the directed scenarios.
module tb_frame_config_ctrl;

  localparam int NC = 8;
  localparam int NF = 20;
  localparam int SC = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [31:0]   s_data;
  logic [31:0]   frame_data;
  logic [NC-1:0] col_sel;
  logic [NF-1:0] frame_strobe;
  logic          busy;
  logic          done;
  logic          err;

  frame_config_ctrl #(
    .NUM_COLS       (NC),
    .FRAMES_PER_COL (NF),
    .STROBE_CYCLES  (SC)
  ) dut (
    .CLK         (clk),
    .RST         (rst),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .FrameData   (frame_data),
    .ColSelect   (col_sel),
    .FrameStrobe (frame_strobe),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          rdy;
    logic          busy;
    logic [31:0]   fd;
    logic [NC-1:0] col;
    logic [NF-1:0] strb;
    logic          done;
    logic          err;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  exp_t        act;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;

  // Model state: what FrameData should hold, and whether err is owed on the next cycle.
  logic [31:0] m_fd;
  logic        m_err;
  logic [31:0] m_last_xor;
  logic [31:0] w [NF];
`ifdef FRAME_CHECKSUM_EN
  logic [31:0] trl;
`endif

  int            done_seen;
  int            err_seen;
  int            strb_cyc [NF];
  logic [NC-1:0] col_seen;

  // Compare every cycle against the expected waveform and accumulate observations.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      act = '{s_ready, busy, frame_data, col_sel, frame_strobe, done, err};
      checks++;
      if (act !== cur) begin
        failures++;
        $display("FAIL cycle_%0d got rdy=%b busy=%b fd=%h col=%h strb=%h done=%b err=%b want rdy=%b busy=%b fd=%h col=%h strb=%h done=%b err=%b",
                 cyc, act.rdy, act.busy, act.fd, act.col, act.strb, act.done, act.err,
                 cur.rdy, cur.busy, cur.fd, cur.col, cur.strb, cur.done, cur.err);
      end
    end
    if (done === 1'b1) done_seen++;
    if (err === 1'b1) err_seen++;
    for (int b = 0; b < NF; b++) if (frame_strobe[b] === 1'b1) strb_cyc[b]++;
    col_seen = col_seen | col_sel;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic clr();
    done_seen = 0;
    err_seen  = 0;
    col_seen  = '0;
    for (int b = 0; b < NF; b++) strb_cyc[b] = 0;
  endtask

  // One clock: drive inputs, queue the outputs expected during this cycle, advance.
  task automatic step(input logic v, input logic [31:0] d, input logic rdy, input logic bsy,
                      input logic [NC-1:0] col, input logic [NF-1:0] st, input logic dn);
    exp_t e;
    s_valid = v;
    s_data  = d;
    e = '{rdy, bsy, m_fd, col, st, dn, m_err};
    exp_q.push_back(e);
    m_err = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 32'h0, 1'b1, 1'b0, '0, '0, 1'b0);
  endtask

  // Expand a header and its frame words (from w[]) into the expected waveform.
  task automatic run_col(input logic [31:0] hdr, input int stall);
    int c;
    int n;
    logic [31:0] x;
    c = int'(hdr[15:8]);
    n = int'(hdr[7:0]);
    step(1'b1, hdr, 1'b1, 1'b0, '0, '0, 1'b0);
    if (hdr[31:16] != 16'hFAB0 || c >= NC || n < 1 || n > NF) begin
      m_err = 1'b1;
      return;
    end
    x = 32'h0;
    for (int j = 0; j < n; j++) begin
      for (int k = 0; k < stall; k++) step(1'b0, 32'h0BAD_0000, 1'b1, 1'b1, '0, '0, 1'b0);
      step(1'b1, w[j], 1'b1, 1'b1, '0, '0, 1'b0);
      m_fd = w[j];
      x    = x ^ w[j];
      // Junk offered while not ready must not be taken.
      for (int k = 0; k < SC; k++)
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, NC'(1) << c, NF'(1) << j, 1'b0);
      step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, '0, '0, 1'b0);
    end
    m_last_xor = x;
`ifdef FRAME_CHECKSUM_EN
    step(1'b1, trl, 1'b1, 1'b1, '0, '0, 1'b0);
    if (trl != x) begin
      m_err = 1'b1;
      return;
    end
`endif
    step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, '0, '0, 1'b1);
  endtask

  initial begin
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = 32'h0;
    m_fd    = 32'h0;
    m_err   = 1'b0;
    m_last_xor = 32'h0;
    for (int j = 0; j < NF; j++) w[j] = 32'h0;
`ifdef FRAME_CHECKSUM_EN
    trl = 32'h0;
`endif
    clr();
    @(posedge clk);
    #1;
    // Reset state: not ready, all outputs low.
    step(1'b1, 32'hFAB0_0101, 1'b0, 1'b0, '0, '0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, '0, '0, 1'b0);
    rst = 1'b0;
    idle(2);

    // Two-frame load into column 3.
    clr();
    w[0] = 32'h1234_5678;
    w[1] = 32'h0000_FFFF;
`ifdef FRAME_CHECKSUM_EN
    trl = 32'h1234_A987;
`endif
    run_col(32'hFAB0_0302, 0);
    idle(2);
    chk("basic_done_count", done_seen, 1);
    chk("basic_err_count", err_seen, 0);
    chk("basic_strobe0_cycles", strb_cyc[0], 2);
    chk("basic_strobe1_cycles", strb_cyc[1], 2);
    chk("basic_colsel", {24'd0, col_seen}, 32'h08);
    chk("model_xor", m_last_xor, 32'h1234_A987);

    // Bad sync, immediately followed by a good header.
    clr();
    run_col(32'hFAB1_0001, 0);
    chk("badsync_no_strobe", strb_cyc[0], 0);
    w[0] = 32'hCAFE_F00D;
`ifdef FRAME_CHECKSUM_EN
    trl = 32'hCAFE_F00D;
`endif
    run_col(32'hFAB0_0101, 0);
    idle(1);
    chk("badsync_err_count", err_seen, 1);
    chk("recover_done_count", done_seen, 1);
    chk("recover_colsel", {24'd0, col_seen}, 32'h02);

    // Out-of-range column/count and zero count are all rejected.
    clr();
    run_col(32'hFAB0_0815, 0);
    idle(1);
    run_col(32'hFAB0_0700, 0);
    idle(1);
    run_col(32'hFAB0_0715, 0);
    idle(2);
    chk("range_err_count", err_seen, 3);
    chk("range_done_count", done_seen, 0);
    chk("range_colsel", {24'd0, col_seen}, 32'h0);

    // Single frame with a 10-cycle stall before the data word.
    clr();
    w[0] = 32'h5A5A_A5A5;
`ifdef FRAME_CHECKSUM_EN
    trl = 32'h5A5A_A5A5;
`endif
    run_col(32'hFAB0_0201, 10);
    idle(1);
    chk("stall_done_count", done_seen, 1);
    chk("stall_strobe0_cycles", strb_cyc[0], 2);

    // Largest legal column and frame count.
    clr();
    for (int j = 0; j < NF; j++) w[j] = 32'(j + 1) * 32'h0101_0101 ^ 32'h8000_0001;
`ifdef FRAME_CHECKSUM_EN
    trl = 32'h0;
    for (int j = 0; j < NF; j++) trl = trl ^ w[j];
`endif
    run_col(32'hFAB0_0714, 0);
    idle(1);
    chk("max_done_count", done_seen, 1);
    chk("max_strobe19_cycles", strb_cyc[19], 2);
    chk("max_colsel", {24'd0, col_seen}, 32'h80);

    // Reset during the second strobe clock abandons the load.
    clr();
    w[0] = 32'h1111_2222;
    step(1'b1, 32'hFAB0_0102, 1'b1, 1'b0, '0, '0, 1'b0);
    step(1'b1, w[0], 1'b1, 1'b1, '0, '0, 1'b0);
    m_fd = w[0];
    step(1'b0, 32'h0, 1'b0, 1'b1, NC'(2), NF'(1), 1'b0);
    rst   = 1'b1;
    m_fd  = 32'h0;
    m_err = 1'b0;
    step(1'b0, 32'h0, 1'b0, 1'b0, '0, '0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, '0, '0, 1'b0);
    rst = 1'b0;
    idle(1);
    chk("reset_no_done", done_seen, 0);
    chk("reset_strobe0_cycles", strb_cyc[0], 1);
    w[0] = 32'h7777_0001;
`ifdef FRAME_CHECKSUM_EN
    trl = 32'h7777_0001;
`endif
    run_col(32'hFAB0_0001, 0);
    idle(1);
    chk("after_reset_done", done_seen, 1);

`ifdef FRAME_CHECKSUM_EN
    // Checksum mismatch: err instead of done.
    clr();
    w[0] = 32'hAAAA_0000;
    w[1] = 32'h0000_5555;
    trl  = 32'hAAAA_5554;
    run_col(32'hFAB0_0002, 0);
    idle(2);
    chk("csum_err_count", err_seen, 1);
    chk("csum_done_count", done_seen, 0);
    chk("csum_strobe1_cycles", strb_cyc[1], 2);
`endif

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_config_ctrl.md
FRAME_CONFIG_CTRL -- requirements
Module: frame_config_ctrl

Interface
REQ-001 Parameter NUM_COLS, default 8: number of fabric columns addressable via ColSelect.
REQ-002 Parameter FRAMES_PER_COL, default 20: number of frame strobes per column.
REQ-003 Parameter STROBE_CYCLES, default 2: width of each FrameStrobe pulse in clocks, legal range 1..15.
REQ-004 CLK  input  1: single clock; all state on rising edge.
REQ-005 RST  input  1: reset, asynchronous assert, active-high.
REQ-006 s_valid  input  1: stream word valid.
REQ-007 s_ready  output  1: stream word accepted when s_valid and s_ready are both 1 on a rising edge.
REQ-008 s_data  input  32: stream word, either a header or frame data.
REQ-009 FrameData  output  32: registered frame word driven to the configuration latches.
REQ-010 ColSelect  output  NUM_COLS: one-hot column enable, asserted only while FrameStrobe is nonzero.
REQ-011 FrameStrobe  output  FRAMES_PER_COL: one-hot latch-enable pulse for the current frame.
REQ-012 busy  output  1: high in every state except IDLE.
REQ-013 done  output  1: one-cycle pulse when a column load completes.
REQ-014 err  output  1: one-cycle pulse when a header or checksum is rejected.

Function
REQ-015 Header format: [31:16] sync = 16'hFAB0; [15:8] column index C; [7:0] frame count N.
REQ-016 States: IDLE, LOAD, STROBE, HOLD, CHECK, DONE.
REQ-017 In IDLE, s_ready = 1 and each accepted word is treated as a header.
REQ-018 A header is valid only if sync matches, C < NUM_COLS, and 1 <= N <= FRAMES_PER_COL.
REQ-019 A valid header latches C and N, clears frame index i to 0, and moves to LOAD.
REQ-020 An invalid header pulses err on the next cycle and the FSM stays in IDLE.
REQ-021 In LOAD, s_ready = 1; an accepted word is registered into FrameData and the FSM moves to STROBE.
REQ-022 In STROBE, s_ready = 0, FrameStrobe[i] = 1 and ColSelect[C] = 1 for exactly STROBE_CYCLES clocks, with FrameData held stable.
REQ-023 In HOLD (exactly 1 clock), strobes are 0 and FrameData is held, which gives the latches hold time.
REQ-024 After HOLD: if i == N-1, the FSM goes to CHECK; otherwise i increments and the FSM returns to LOAD.
REQ-025 The first FrameStrobe edge follows the data-word accept by 1 clock, so per-frame throughput is STROBE_CYCLES+2 clocks.
REQ-026 DONE lasts 1 clock, pulses done, then returns to IDLE.
REQ-027 s_valid low in LOAD stalls indefinitely with no strobes; no timeout.
REQ-028 At most one bit of FrameStrobe and one bit of ColSelect is ever high; both are all-zero outside STROBE.
REQ-029 The strobe-cycle counter is 4 bits wide; i is wide enough for FRAMES_PER_COL-1.

Reset
REQ-030 RST = 1 forces, asynchronously, the state to IDLE and these outputs to 0: FrameData, ColSelect, FrameStrobe, busy, done, err.
REQ-031 While RST = 1, s_ready = 0; after release s_ready = 1 (IDLE).
REQ-032 Reset during STROBE drops FrameStrobe within the same cycle, and the partial column load is abandoned.

Configuration
REQ-033 Macro FRAME_CHECKSUM_EN.
REQ-034 With FRAME_CHECKSUM_EN defined, CHECK accepts one trailer word (s_ready = 1) and compares it with the XOR of the N data words.
REQ-035 With FRAME_CHECKSUM_EN defined, a match goes to DONE; a mismatch pulses err, skips done, and returns to IDLE (frames already strobed stay written).
REQ-036 With FRAME_CHECKSUM_EN undefined, CHECK lasts 0 clocks (HOLD goes directly to DONE), no trailer is consumed, and the XOR register is not built.

Verification
REQ-037 Header 32'hFAB0_0302, then data 32'h1234_5678 and 32'h0000_FFFF (plus trailer 32'h1234_A987 if checksum enabled) -> ColSelect = 8'h08 with FrameStrobe bit0 for 2 clocks, then bit1 for 2 clocks; FrameData matches each word; done pulses once.
REQ-038 Header 32'hFAB1_0001 -> err pulses 1 clock, no strobes, next valid header is accepted normally.
REQ-039 Header 32'hFAB0_0815 (C = 8, N = 21) -> err pulses, FSM remains in IDLE.
REQ-040 Valid N = 1 load with s_valid deasserted 10 clocks in LOAD -> no strobe until the word arrives; busy stays 1 throughout.
REQ-041 RST asserted during the second STROBE clock -> FrameStrobe, ColSelect and busy go to 0 immediately; after release, a header is accepted.
REQ-042 With FRAME_CHECKSUM_EN defined, N = 2 data 32'hAAAA_0000 and 32'h0000_5555 with trailer 32'hAAAA_5554 -> err pulses and done does not.
